// File: rtl/pdcch_fifo_arbiter.sv
// pdcch_fifo_arbiter: round-robin, packet-granular N:1 AXI-Stream arbiter
// feeding the single write port of the PDCCH sync FIFO.
// A grant is held until the source's last beat or until MAX_BURST beats.
// Optional macro ARB_TIMEOUT_EN: revoke a grant whose source stays idle for
// TIMEOUT cycles and pulse timeout_err; undefined, timeout_err is tied 0.
module pdcch_fifo_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64,
    parameter int ID_W       = $clog2(NUM_SRC),
    parameter int TIMEOUT    = 256
) (
    input  logic                          aclk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    input  logic [NUM_SRC-1:0]            s_axis_last,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    output logic                          m_axis_valid,
    output logic                          m_axis_last,
    output logic [ID_W-1:0]               m_axis_id,
    input  logic                          m_axis_ready,
    output logic                          grant_active,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("pdcch_fifo_arbiter: NUM_SRC must be in 2..8");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("pdcch_fifo_arbiter: MAX_BURST must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pdcch_fifo_arbiter: TIMEOUT must be >= 1");
    end

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     grant_id, grant_nxt;
    logic [ID_W-1:0]     last_grant, last_grant_nxt;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic [ID_W-1:0]     rr_pick;
    logic                rr_found;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                sel_valid;
    logic                sel_last;
    logic                beat_acc;
    logic                revoke;

    // Round-robin search starting one past the previous grant
    always_comb begin
        int unsigned idx;
        rr_pick  = '0;
        rr_found = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (!rr_found && s_axis_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = ID_W'(idx);
            end
        end
    end

    // Select the granted source's beat, valid and last
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_data  = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_valid[i];
                sel_last  = s_axis_last[i];
            end
        end
    end

    // Output pass-through while a grant is active; everything quiet in IDLE
    always_comb begin
        s_axis_ready = '0;
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        m_axis_id    = '0;
        grant_active = 1'b0;
        if (state == XFER) begin
            m_axis_data  = sel_data;
            m_axis_valid = sel_valid;
            m_axis_last  = sel_last || (beat_cnt == BURST_LAST);
            m_axis_id    = grant_id;
            grant_active = 1'b1;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                s_axis_ready[i] = (ID_W'(i) == grant_id) && m_axis_ready;
            end
        end
    end

    assign beat_acc = m_axis_valid && m_axis_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_q;

    assign revoke      = (state == XFER) && !sel_valid && (idle_cnt == IDLE_LAST);
    assign timeout_err = timeout_q;

    // Count consecutive idle-valid cycles of the granted source; pulse on revoke
    always_ff @(posedge aclk) begin
        if (!reset) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            if (state != XFER || sel_valid || revoke) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign revoke      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, hold the grant through XFER
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt    = rr_pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = XFER;
                end
            end
            XFER: begin
                if (beat_acc) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (m_axis_last) begin
                        last_grant_nxt = grant_id;
                        state_nxt      = IDLE;
                    end
                end else if (revoke) begin
                    last_grant_nxt = grant_id;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_SRC - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

endmodule
